// File: rtl/user_project_wb_xbar_if.sv
// user_project_wb_xbar_if
//   Bus bundle for the 1-to-N Wishbone splitter: the upstream Caravel
//   management port (wbs_*) and the shared/per-slave downstream port (m_*).
//   Signal suffixes are from the splitter's point of view.
//   modport slave  : the splitter (Wishbone slave upstream, master downstream)
//   modport master : the environment (Caravel master + downstream slaves)
interface user_project_wb_xbar_if #(
   parameter int NUM_SLAVES = 4,
   parameter int WIN_BITS   = 16
);
   // upstream
   logic                               wbs_cyc_i;
   logic                               wbs_stb_i;
   logic                               wbs_we_i;
   logic [3:0]                         wbs_sel_i;
   logic [31:0]                        wbs_adr_i;
   logic [31:0]                        wbs_dat_i;
   logic                               wbs_ack_o;
   logic [31:0]                        wbs_dat_o;
   // downstream; m_dat_i element k occupies bits [32k+31:32k]
   logic [NUM_SLAVES-1:0]              m_cyc_o;
   logic [NUM_SLAVES-1:0]              m_stb_o;
   logic                               m_we_o;
   logic [3:0]                         m_sel_o;
   logic [WIN_BITS-1:0]                m_adr_o;
   logic [31:0]                        m_dat_o;
   logic [NUM_SLAVES-1:0][31:0]        m_dat_i;
   logic [NUM_SLAVES-1:0]              m_ack_i;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
      input  m_dat_i, m_ack_i
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
      output m_dat_i, m_ack_i
   );
endinterface

// File: rtl/user_project_wb_xbar.sv
// user_project_wb_xbar
//   Parametrised 1-to-NUM_SLAVES Wishbone splitter. Decodes the upstream
//   address into 2**WIN_BITS-byte windows starting at BASE_ADDR, runs one
//   transaction at a time, registers the response and answers unmapped
//   addresses or slave timeouts with ERR_DATA plus an error pulse.
// Ports
//   wb_clk_i     bus clock
//   wb_rst_i     synchronous active-high reset
//   bus          user_project_wb_xbar_if.slave (wbs_* upstream, m_* downstream)
//   err_irq_o    one-cycle pulse on every error response
//   err_count_o  saturating 8-bit error counter

// Per-slave lane: strobe generation and response qualification for slave K.
// Non-selected lanes contribute zero, so the top can simply OR all lanes.
module user_project_wb_xbar_lane #(
   parameter int K     = 0,
   parameter int IDX_W = 2
) (
   input  logic             busy_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             ack_i,
   input  logic [31:0]      dat_i,
   output logic             stb_o,
   output logic             ack_o,
   output logic [31:0]      dat_o
);
   logic sel;
   assign sel   = busy_i && (idx_i == IDX_W'(K));
   assign stb_o = sel;
   assign ack_o = sel & ack_i;
   assign dat_o = sel ? dat_i : '0;
endmodule

module user_project_wb_xbar #(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          WIN_BITS   = 16,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   user_project_wb_xbar_if.slave   bus,
   output logic                    err_irq_o,
   output logic [7:0]              err_count_o
);
   localparam int          IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_ERR} state_t;

   state_t              state_q, state_d;
   logic [15:0]         timer_q, timer_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [WIN_BITS-1:0] adr_q, adr_d;
   logic [31:0]         wdat_q, wdat_d;
   logic [31:0]         rdat_q, rdat_d;
   logic [7:0]          cnt_q, cnt_d;

   // ---------------- address decode ----------------
   logic [31:0] off, win;
   logic        hit;
   assign off = bus.wbs_adr_i - BASE_ADDR;
   assign win = off >> WIN_BITS;
   // The lower-bound test matters: below BASE_ADDR the subtraction wraps.
   assign hit = (bus.wbs_adr_i >= BASE_ADDR) && (win < 32'(NUM_SLAVES));

   // ---------------- per-slave lanes ----------------
   logic                       busy;
   logic [NUM_SLAVES-1:0]      lane_stb, lane_ack;
   logic [NUM_SLAVES-1:0][31:0] lane_dat;
   logic                       any_ack;
   logic [31:0]                sel_dat;

   assign busy = (state_q == S_BUSY);

   for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_lane
      user_project_wb_xbar_lane #(.K(k), .IDX_W(IDX_W)) u_lane (
         .busy_i (busy),
         .idx_i  (idx_q),
         .ack_i  (bus.m_ack_i[k]),
         .dat_i  (bus.m_dat_i[k]),
         .stb_o  (lane_stb[k]),
         .ack_o  (lane_ack[k]),
         .dat_o  (lane_dat[k])
      );
   end

   // Only the selected lane can be non-zero, so OR-reduction is a mux.
   always_comb begin
      sel_dat = '0;
      for (int k = 0; k < NUM_SLAVES; k++) sel_dat = sel_dat | lane_dat[k];
   end
   assign any_ack = |lane_ack;

   // ---------------- FSM next state ----------------
   logic [7:0] cnt_inc;
   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
               idx_d   = win[IDX_W-1:0];
               we_d    = bus.wbs_we_i;
               sel_d   = bus.wbs_sel_i;
               adr_d   = off[WIN_BITS-1:0];
               wdat_d  = bus.wbs_dat_i;
               timer_d = '0;
               if (hit) begin
                  state_d = S_BUSY;
               end else begin
                  // Error response data and count are set up on entry so
                  // they are visible in the same cycle as the ack.
                  rdat_d  = ERR_DATA;
                  cnt_d   = cnt_inc;
                  state_d = S_ERR;
               end
            end
         end
         S_BUSY: begin
            timer_d = timer_q + 16'd1;
            if (!bus.wbs_cyc_i) begin
               // master abandoned the cycle: silent return, no ack
               state_d = S_IDLE;
            end else if (any_ack) begin
               // ack is checked before the timeout so a last-cycle ack wins
               rdat_d  = we_q ? 32'd0 : sel_dat;
               state_d = S_RESP;
            end else if (timer_q == TMO_LAST) begin
               rdat_d  = ERR_DATA;
               cnt_d   = cnt_inc;
               state_d = S_ERR;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- outputs (all decoded from registers) ----------------
   assign bus.wbs_ack_o = (state_q == S_RESP) || (state_q == S_ERR);
   assign bus.wbs_dat_o = rdat_q;
   assign bus.m_cyc_o   = lane_stb;
   assign bus.m_stb_o   = lane_stb;
   assign bus.m_we_o    = we_q;
   assign bus.m_sel_o   = sel_q;
   assign bus.m_adr_o   = adr_q;
   assign bus.m_dat_o   = wdat_q;
   assign err_irq_o     = (state_q == S_ERR);
   assign err_count_o   = cnt_q;
endmodule
